// File: rtl/simple_mem_slave_pkg.sv
// simple_mem_slave_pkg: shared bus widths and slave FSM states
package simple_mem_slave_pkg;
   localparam int dataW  = 32;
   localparam int beW    = 4;
   localparam int burstW = 8;
   typedef enum logic [2:0] {IDLE, RD, RD_END, WR, ERR, WR_DROP} stateT;
endpackage

// File: rtl/simple_mem_slave_ram.sv
// simple_mem_slave_ram: synchronous-read word RAM with per-byte write enables
module simple_mem_slave_ram
   import simple_mem_slave_pkg::*;
#(
   parameter int words = 262144,
   parameter int idxW  = 18
) (
   input  logic              clk_i,
   input  logic              we,
   input  logic [beW-1:0]    be,
   input  logic [idxW-1:0]   addr,
   input  logic [dataW-1:0]  wData,
   output logic [dataW-1:0]  rData
);
   logic [dataW-1:0] mem [words];
   // byte-lane write and registered read; contents are never reset
   always_ff @(posedge clk_i) begin
      if (we)
         for (int b = 0; b < beW; b++)
            if (be[b]) mem[addr][8*b +: 8] <= wData[8*b +: 8];
      rData <= mem[addr];
   end
endmodule

// File: rtl/simple_mem_slave.sv
// simple_mem_slave: word-addressed RAM slave with bursts, byte enables and range error
module simple_mem_slave
   import simple_mem_slave_pkg::*;
#(
   parameter logic [31:0] baseAddr = 32'h00000000,
   parameter int          memSize  = 262144
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [dataW-1:0]  bus_addrData_i,
   input  logic [beW-1:0]    bus_byteEnables_i,
   input  logic [burstW-1:0] bus_burstSize_i,
   input  logic              bus_readNWrite_i,
   input  logic              bus_beginTransaction_i,
   input  logic              bus_endTransaction_i,
   input  logic              bus_dataValid_i,
   output logic [dataW-1:0]  bus_addrData_o,
   output logic              bus_endTransaction_o,
   output logic              bus_dataValid_o,
   output logic              bus_busy_o,
   output logic              bus_error_o
);
   localparam int          idxW     = $clog2(memSize);
   localparam logic [32:0] winBytes = 33'(memSize) << 2;

   stateT               state, nextState;
   logic [idxW-1:0]     idx;
   logic [8:0]          cnt;
   logic [burstW-1:0]   burst;
   logic [beW-1:0]      be;
   logic                isRead, rdValid, selected, outOfRange, accept, ramWe;
   logic [32:0]         offset, lastIdx;
   logic [dataW-1:0]    ramData;

   assign offset     = {1'b0, bus_addrData_i} - {1'b0, baseAddr};
   assign selected   = bus_addrData_i >= baseAddr && offset < winBytes;
   assign lastIdx    = {2'b0, offset[32:2]} + 33'(bus_burstSize_i);
   assign outOfRange = lastIdx >= 33'(memSize);
   assign accept     = state == IDLE && bus_beginTransaction_i && selected;
   assign ramWe      = state == WR && bus_dataValid_i && cnt <= {1'b0, burst};

   simple_mem_slave_ram #(.words(memSize), .idxW(idxW)) ram (
      .clk_i (clk_i),
      .we    (ramWe),
      .be    (be),
      .addr  (idx),
      .wData (bus_addrData_i),
      .rData (ramData)
   );

   // next state: RD lingers one cycle past the last issued read so the end strobe trails the last word
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = outOfRange ? ERR : (bus_readNWrite_i ? RD : WR);
         RD:      nextState = bus_endTransaction_i ? IDLE : (cnt == {1'b0, burst} + 9'd1 ? RD_END : RD);
         RD_END:  nextState = IDLE;
         WR:      nextState = bus_endTransaction_i ? IDLE : WR;
         ERR:     nextState = (isRead || bus_endTransaction_i) ? IDLE : WR_DROP;
         WR_DROP: nextState = bus_endTransaction_i ? IDLE : WR_DROP;
         default: nextState = IDLE;
      endcase
   end

   // state, burst bookkeeping and read-valid pipeline stage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         burst   <= '0;
         be      <= '0;
         isRead  <= 1'b0;
         rdValid <= 1'b0;
      end else begin
         state   <= nextState;
         rdValid <= state == RD && !bus_endTransaction_i && cnt <= {1'b0, burst};
         if (accept) begin
            idx    <= offset[idxW+1:2];
            cnt    <= '0;
            burst  <= bus_burstSize_i;
            be     <= bus_byteEnables_i;
            isRead <= bus_readNWrite_i;
         end else if (state == RD || ramWe) begin
            idx <= idx + 1'b1;
            cnt <= cnt + 9'd1;
         end
      end
   end

   assign bus_addrData_o       = rdValid ? ramData : '0;
   assign bus_dataValid_o      = rdValid;
   assign bus_endTransaction_o = state == RD_END || state == ERR;
   assign bus_error_o          = state == ERR;
   assign bus_busy_o           = 1'b0;
endmodule

// File: tb/tb_simple_mem_slave.sv
// tb_simple_mem_slave: directed checks of read/write timing, byte enables, range error, abort and reset
module tb_simple_mem_slave;
   logic        clk = 0, rst_n = 0;
   logic [31:0] addrDataIn = 0;
   logic [3:0]  beIn = 0;
   logic [7:0]  burstIn = 0;
   logic        rnwIn = 0, beginIn = 0, endIn = 0, dvIn = 0;
   logic [31:0] addrDataOut;
   logic        endOut, dvOut, busyOut, errOut;
   int          compared = 0, mismatched = 0;

   simple_mem_slave dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .bus_addrData_i         (addrDataIn),
      .bus_byteEnables_i      (beIn),
      .bus_burstSize_i        (burstIn),
      .bus_readNWrite_i       (rnwIn),
      .bus_beginTransaction_i (beginIn),
      .bus_endTransaction_i   (endIn),
      .bus_dataValid_i        (dvIn),
      .bus_addrData_o         (addrDataOut),
      .bus_endTransaction_o   (endOut),
      .bus_dataValid_o        (dvOut),
      .bus_busy_o             (busyOut),
      .bus_error_o            (errOut)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] flags();
      return {28'b0, endOut, dvOut, busyOut, errOut};
   endfunction

   task automatic startTx(input logic [31:0] addr, input logic rnw, input logic [7:0] bs, input logic [3:0] be);
      addrDataIn = addr;
      rnwIn      = rnw;
      burstIn    = bs;
      beIn       = be;
      beginIn    = 1;
      tick();
      beginIn    = 0;
      addrDataIn = 0;
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] bs, input int n, input logic [31:0] first);
      startTx(addr, 0, bs, be);
      for (int i = 0; i < n; i++) begin
         addrDataIn = first + i;
         dvIn = 1;
         tick();
      end
      dvIn = 0;
      addrDataIn = 0;
      endIn = 1;
      tick();
      endIn = 0;
   endtask

   task automatic doRead(input string tag, input logic [31:0] addr, input logic [7:0] bs, input logic [31:0] first);
      startTx(addr, 1, bs, 4'hF);
      chk({tag, "_lat"}, flags(), 32'h0);
      for (int i = 0; i <= int'(bs); i++) begin
         tick();
         chk({tag, "_dv"}, {31'b0, dvOut}, 32'h1);
         chk({tag, "_data"}, addrDataOut, first + i);
      end
      tick();
      chk({tag, "_endstrobe"}, flags(), 32'h8);
      chk({tag, "_enddata"}, addrDataOut, 32'h0);
      tick();
      chk({tag, "_idle"}, flags(), 32'h0);
   endtask

   initial begin
      #2;
      chk("reset_flags", flags(), 32'h0);
      chk("reset_data", addrDataOut, 32'h0);
      @(negedge clk) rst_n = 1;
      tick();
      // single write then read
      doWrite(32'h100, 4'hF, 0, 1, 32'hDEADBEEF);
      doRead("single", 32'h100, 0, 32'hDEADBEEF);
      // byte-enable merge
      doWrite(32'h100, 4'b0101, 0, 1, 32'h11223344);
      doRead("bytemask", 32'h100, 0, 32'hDE22BE44);
      // burst of four
      doWrite(32'h200, 4'hF, 3, 4, 32'h0);
      doRead("burst", 32'h200, 3, 32'h0);
      // last legal word, then out-of-range read and write
      doWrite(32'h000FFFFC, 4'hF, 0, 1, 32'hCAFEF00D);
      doRead("topword", 32'h000FFFFC, 0, 32'hCAFEF00D);
      startTx(32'h000FFFFC, 1, 1, 4'hF);
      chk("rderr_strobe", flags(), 32'h9);
      tick();
      chk("rderr_after", flags(), 32'h0);
      tick();
      chk("rderr_nodata", flags(), 32'h0);
      startTx(32'h000FFFFC, 0, 1, 4'hF);
      chk("wrerr_strobe", flags(), 32'h9);
      for (int i = 0; i < 2; i++) begin
         addrDataIn = 32'h5555AAAA + i;
         dvIn = 1;
         tick();
         chk("wrerr_quiet", flags(), 32'h0);
      end
      dvIn = 0;
      endIn = 1;
      tick();
      endIn = 0;
      doRead("wrerr_unchanged", 32'h000FFFFC, 0, 32'hCAFEF00D);
      // unselected address
      startTx(32'h60000000, 1, 0, 4'hF);
      for (int i = 0; i < 4; i++) begin
         chk("unsel_flags", flags(), 32'h0);
         chk("unsel_data", addrDataOut, 32'h0);
         tick();
      end
      // abort a read with the master end strobe
      startTx(32'h200, 1, 3, 4'hF);
      tick();
      chk("abort_word0", addrDataOut, 32'h0);
      chk("abort_dv", {31'b0, dvOut}, 32'h1);
      endIn = 1;
      tick();
      endIn = 0;
      chk("abort_flags", flags(), 32'h0);
      chk("abort_data", addrDataOut, 32'h0);
      tick();
      chk("abort_noend", flags(), 32'h0);
      doRead("after_abort", 32'h100, 0, 32'hDE22BE44);
      // asynchronous reset mid-burst
      startTx(32'h200, 1, 3, 4'hF);
      tick();
      tick();
      chk("prerst_data", addrDataOut, 32'h1);
      #2 rst_n = 0;
      #1;
      chk("rst_flags", flags(), 32'h0);
      chk("rst_data", addrDataOut, 32'h0);
      @(negedge clk) rst_n = 1;
      tick();
      chk("postrst_idle", flags(), 32'h0);
      doRead("after_reset", 32'h200, 3, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
